// File: rtl/seq_borrow_subtractor.sv
// rtl/seq_borrow_subtractor.sv - multi-cycle signed subtractor, CHUNK bits per cycle, LSB chunk first
//
// Computes diff = a - b - bin as a + ~b + ~bin, one CHUNK-wide slice per cycle,
// with the carry rippling between slices in a register.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is high only in IDLE)
//   a, b, bin             minuend, subtrahend, borrow in (captured on accept)
//   out_valid / out_ready result handshake (out_valid is high only in DONE)
//   diff, bout, overflow  result, borrow out, signed overflow (held until next DONE entry)
module seq_borrow_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;       // inverted subtrahend
    logic             c_q, c_d;         // inter-chunk carry (inverted borrow)
    logic [WIDTH-1:0] acc_q, acc_d;     // partial result, filled from the top
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             overflow_q, overflow_d;

    logic             accept;
    logic             last_chunk;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] acc_next;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            nb_q       <= '0;
            c_q        <= 1'b0;
            acc_q      <= '0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            nb_q       <= nb_d;
            c_q        <= c_d;
            acc_q      <= acc_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            overflow_q <= overflow_d;
        end
    end

    assign accept     = (state_q == IDLE) && in_valid;
    assign last_chunk = (cnt_q == CW'(N - 1));

    // Operands shift right by CHUNK each cycle, so the active slice is always at bit 0.
    assign sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, nb_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
    // Result slices enter at the top; after N shifts the LSB chunk has reached bit 0.
    assign acc_next = (acc_q >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last_chunk) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d      = cnt_q;
        a_d        = a_q;
        nb_d       = nb_q;
        c_d        = c_q;
        acc_d      = acc_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        overflow_d = overflow_q;
        if (accept) begin
            cnt_d   = '0;
            a_d     = a;
            nb_d    = ~b;
            c_d     = ~bin;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + CW'(1);
            a_d   = a_q >> CHUNK;
            nb_d  = nb_q >> CHUNK;
            c_d   = sum[CHUNK];
            acc_d = acc_next;
            if (last_chunk) begin
                cnt_d      = '0;
                diff_d     = acc_next;
                bout_d     = ~sum[CHUNK];
                overflow_d = (a_msb_q != b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
            end
        end
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        diff      = diff_q;
        bout      = bout_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_seq_borrow_subtractor.sv
// tb/tb_seq_borrow_subtractor.sv - self-checking bench for seq_borrow_subtractor
module tb_seq_borrow_subtractor;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    seq_borrow_subtractor #(.WIDTH(W), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
        logic         exp_ovf;
    } vec_t;

    vec_t tab[7];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] md, output logic mbo, output logic mov);
        logic [W:0] lhs;
        logic [W:0] rhs;
        lhs = {1'b0, ma};
        rhs = {1'b0, mb} + {{W{1'b0}}, mbin};
        md  = ma - mb - {{(W-1){1'b0}}, mbin};
        mbo = (lhs < rhs);
        mov = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
    endtask

    // Wait for in_ready, present operands for one accept edge; returns after that edge.
    task automatic start_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        a = ai; b = bi; bin = bini; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                          input int stall, output logic [W-1:0] d, output logic bo,
                          output logic ov, output int lat);
        start_op(ai, bi, bini);
        wait_done(lat);
        d = diff; bo = bout; ov = overflow;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] d, md, hold_d;
        logic         bo, ov, mbo, mov, hold_bo, hold_ov;
        int           lat;

        tab[0] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tab[1] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        tab[2] = '{32'd52,        32'd31,        1'b0, 32'd21,        1'b0, 1'b0};
        tab[3] = '{-32'd495955,   32'd4548,      1'b0, -32'd500503,   1'b0, 1'b0};
        tab[4] = '{32'd0,         32'd0,         1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tab[5] = '{32'd0,         32'd0,         1'b0, 32'd0,         1'b0, 1'b0};
        tab[6] = '{32'd4561,      32'd89,        1'b0, 32'd4472,      1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff",      diff,               32'd0);
        chk("rst_bout",      {31'd0, bout},      32'd0);
        chk("rst_overflow",  {31'd0, overflow},  32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(tab[i].a, tab[i].b, tab[i].bin, 0, d, bo, ov, lat);
            chk($sformatf("vec%0d_diff", i), d, tab[i].exp_diff);
            chk($sformatf("vec%0d_bout", i), {31'd0, bo}, {31'd0, tab[i].exp_bout});
            chk($sformatf("vec%0d_ovf", i),  {31'd0, ov}, {31'd0, tab[i].exp_ovf});
            chk($sformatf("vec%0d_lat", i),  lat, 32'd4);
        end

        // Stall in DONE with noisy inputs
        start_op(32'd1000, 32'd1, 1'b0);
        wait_done(lat);
        hold_d = diff; hold_bo = bout; hold_ov = overflow;
        chk("stall_diff0", hold_d, 32'd999);
        for (int s = 0; s < 5; s++) begin
            in_valid = $urandom_range(0, 1);
            a = $urandom; b = $urandom; bin = $urandom_range(0, 1);
            @(posedge clk); #1;
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
            chk("stall_diff",      diff,               hold_d);
            chk("stall_bout",      {31'd0, bout},      {31'd0, hold_bo});
            chk("stall_ovf",       {31'd0, overflow},  {31'd0, hold_ov});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready",  {31'd0, in_ready},  32'd1);
        chk("idle_hold_diff",    diff,               hold_d);
        // No second accept: stays idle with in_valid low
        @(posedge clk); #1;
        chk("no_extra_accept",   {31'd0, in_ready},  32'd1);

        // Reset during BUSY at chunk 2
        start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_diff",      diff,               32'd0);
        chk("abort_bout",      {31'd0, bout},      32'd0);
        chk("abort_ovf",       {31'd0, overflow},  32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(tab[6].a, tab[6].b, tab[6].bin, 0, d, bo, ov, lat);
        chk("post_abort_diff", d, tab[6].exp_diff);
        chk("post_abort_bout", {31'd0, bo}, {31'd0, tab[6].exp_bout});
        chk("post_abort_ovf",  {31'd0, ov}, {31'd0, tab[6].exp_ovf});
        chk("post_abort_lat",  lat, 32'd4);

        // Randomized operands with random output stalls
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] ra, rb;
            logic         rbin;
            ra = $urandom; rb = $urandom; rbin = $urandom_range(0, 1);
            if (i % 5 == 0) rb = ra;
            if (i % 7 == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
            model(ra, rb, rbin, md, mbo, mov);
            run_op(ra, rb, rbin, $urandom_range(0, 3), d, bo, ov, lat);
            chk("rnd_diff", d, md);
            chk("rnd_bout", {31'd0, bo}, {31'd0, mbo});
            chk("rnd_ovf",  {31'd0, ov}, {31'd0, mov});
            chk("rnd_lat",  lat, 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
